// File: rtl/sparse_chunk_pkg.sv
// rtl/sparse_chunk_pkg.sv - shared bank state type and chunk geometry helpers
package sparse_chunk_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_state_e;

  function automatic int wr_beats(input int chunk_size, input int bus_size);
    return chunk_size / bus_size;
  endfunction

  function automatic int rd_windows(input int chunk_size, input int prefix_sum_size);
    return chunk_size / prefix_sum_size;
  endfunction

  // Index width that never collapses to zero bits for a single-entry space.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_bank.sv
// rtl/chunk_bank.sv - one chunk bank: sparsemap, nonzero data bytes and running nnz
module chunk_bank
  import sparse_chunk_pkg::*;
#(
  parameter int CHUNK_SIZE      = 256,
  parameter int BUS_SIZE        = 128,
  parameter int PREFIX_SUM_SIZE = 32,
  localparam int WR_BEATS   = wr_beats(CHUNK_SIZE, BUS_SIZE),
  localparam int BEAT_W     = width_of(WR_BEATS),
  localparam int RD_WINDOWS = rd_windows(CHUNK_SIZE, PREFIX_SUM_SIZE),
  localparam int WIN_W      = width_of(RD_WINDOWS),
  localparam int IDX_W      = $clog2(CHUNK_SIZE),
  localparam int NNZ_W      = IDX_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic                       first_beat_i,
  input  logic [BEAT_W-1:0]          wr_beat_i,
  input  logic [BUS_SIZE-1:0]        wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]      wr_data_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  input  logic [WIN_W-1:0]           rd_win_i,
  output logic [7:0]                 rd_byte_o,
  output logic [NNZ_W-1:0]           nnz_o,
  output logic [PREFIX_SUM_SIZE-1:0] sparsemap_o
);

  logic [CHUNK_SIZE-1:0] r_sparsemap;
  logic [7:0]            r_data [CHUNK_SIZE];
  logic [NNZ_W-1:0]      r_nnz;
  logic [NNZ_W-1:0]      w_beat_pop;

  always_comb begin
    w_beat_pop = '0;
    for (int j = 0; j < BUS_SIZE; j++) begin
      w_beat_pop = w_beat_pop + NNZ_W'(wr_sparsemap_i[j]);
    end
  end

  // Storage is left unreset; the controller's EMPTY state hides stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_sparsemap[BUS_SIZE*wr_beat_i +: BUS_SIZE] <= wr_sparsemap_i;
      for (int j = 0; j < BUS_SIZE; j++) begin
        r_data[BUS_SIZE*int'(wr_beat_i) + j] <= wr_data_i[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_nnz <= '0;
    end else if (wr_en_i) begin
      r_nnz <= first_beat_i ? w_beat_pop : r_nnz + w_beat_pop;
    end
  end

  assign rd_byte_o   = r_data[rd_idx_i];
  assign nnz_o       = r_nnz;
  assign sparsemap_o = r_sparsemap[PREFIX_SUM_SIZE*rd_win_i +: PREFIX_SUM_SIZE];

endmodule

// File: rtl/sparse_chunk_buffer.sv
// rtl/sparse_chunk_buffer.sv - multi-bank sparse chunk buffer: write controller and read mux
module sparse_chunk_buffer
  import sparse_chunk_pkg::*;
#(
  parameter int CHUNK_SIZE      = 256,
  parameter int BUS_SIZE        = 128,
  parameter int PREFIX_SUM_SIZE = 32,
  parameter int NUM_BANKS       = 2,
  localparam int WR_BEATS   = wr_beats(CHUNK_SIZE, BUS_SIZE),
  localparam int BEAT_W     = width_of(WR_BEATS),
  localparam int RD_WINDOWS = rd_windows(CHUNK_SIZE, PREFIX_SUM_SIZE),
  localparam int WIN_W      = width_of(RD_WINDOWS),
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int IDX_W      = $clog2(CHUNK_SIZE),
  localparam int ADDR_W     = IDX_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [BUS_SIZE-1:0]        wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]      wr_nonzero_data_i,
  output logic                       rd_bank_valid_o,
  output logic [BANK_W-1:0]          rd_bank_o,
  output logic [ADDR_W-1:0]          rd_nnz_o,
  input  logic                       rd_req_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  output logic [7:0]                 rd_data_o,
  output logic                       rd_data_valid_o,
  input  logic [WIN_W-1:0]           rd_sparsemap_addr_i,
  output logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_o,
  input  logic                       rd_release_i
);

  bank_state_e                r_state [NUM_BANKS];
  logic [BANK_W-1:0]          r_wr_ptr;
  logic [BANK_W-1:0]          r_rd_ptr;
  logic [BEAT_W-1:0]          r_beat;
  logic [7:0]                 r_rd_data;
  logic                       r_rd_data_valid;

  logic                       w_wr_fire;
  logic                       w_last_beat;
  logic                       w_rd_full;
  logic                       w_release;
  logic                       w_addr_in_range;
  logic [IDX_W-1:0]           w_rd_idx;
  logic [7:0]                 w_bank_byte [NUM_BANKS];
  logic [ADDR_W-1:0]          w_bank_nnz  [NUM_BANKS];
  logic [PREFIX_SUM_SIZE-1:0] w_bank_win  [NUM_BANKS];

  assign wr_ready_o      = (r_state[r_wr_ptr] != BANK_FULL);
  assign w_wr_fire       = wr_valid_i && wr_ready_o;
  assign w_last_beat     = (r_beat == BEAT_W'(WR_BEATS - 1));
  assign w_rd_full       = (r_state[r_rd_ptr] == BANK_FULL);
  assign w_release       = rd_release_i && w_rd_full;
  assign w_addr_in_range = (rd_addr_i != '0) && (rd_addr_i <= ADDR_W'(CHUNK_SIZE));
  // Addresses are 1-based; storage index is address minus one.
  assign w_rd_idx        = IDX_W'(rd_addr_i - ADDR_W'(1));

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    chunk_bank #(
      .CHUNK_SIZE      (CHUNK_SIZE),
      .BUS_SIZE        (BUS_SIZE),
      .PREFIX_SUM_SIZE (PREFIX_SUM_SIZE)
    ) u_bank (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_en_i        (w_wr_fire && (r_wr_ptr == BANK_W'(g))),
      .first_beat_i   (r_state[g] == BANK_EMPTY),
      .wr_beat_i      (r_beat),
      .wr_sparsemap_i (wr_sparsemap_i),
      .wr_data_i      (wr_nonzero_data_i),
      .rd_idx_i       (w_rd_idx),
      .rd_win_i       (rd_sparsemap_addr_i),
      .rd_byte_o      (w_bank_byte[g]),
      .nnz_o          (w_bank_nnz[g]),
      .sparsemap_o    (w_bank_win[g])
    );
  end

  // A bank being written is never FULL and a released bank always is, so the
  // write and release branches can never target the same bank in one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= BANK_EMPTY;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_beat   <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_wr_fire && (r_wr_ptr == BANK_W'(b))) begin
          r_state[b] <= w_last_beat ? BANK_FULL : BANK_FILL;
        end else if (w_release && (r_rd_ptr == BANK_W'(b))) begin
          r_state[b] <= BANK_EMPTY;
        end
      end
      if (w_wr_fire) begin
        r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
        if (w_last_beat) begin
          r_wr_ptr <= r_wr_ptr + BANK_W'(1);
        end
      end
      if (w_release) begin
        r_rd_ptr <= r_rd_ptr + BANK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_data       <= 8'h00;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_rd_data_valid <= rd_req_i && w_rd_full;
      if (rd_req_i) begin
        r_rd_data <= (w_rd_full && w_addr_in_range) ? w_bank_byte[r_rd_ptr] : 8'h00;
      end
    end
  end

  assign rd_bank_valid_o = w_rd_full;
  assign rd_bank_o       = r_rd_ptr;
  assign rd_nnz_o        = w_bank_nnz[r_rd_ptr];
  assign rd_sparsemap_o  = w_bank_win[r_rd_ptr];
  assign rd_data_o       = r_rd_data;
  assign rd_data_valid_o = r_rd_data_valid;

endmodule
